// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory request arbiter.
package mem_arb_pkg;

    localparam int unsigned NrPortsDefault   = 3;
    localparam int unsigned TidWidthDefault  = 2;
    localparam int unsigned AddrWidthDefault = 64;
    localparam int unsigned DataWidthDefault = 64;
    localparam int unsigned MaxStoresDefault = 7;

    // Upper bound on requesters supported by the round-robin helper.
    localparam int unsigned MaxPorts     = 8;
    localparam int unsigned PortIdxWidth = $clog2(MaxPorts);
    localparam int unsigned PortCntWidth = PortIdxWidth + 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    typedef struct packed {
        logic                    valid;
        logic [PortIdxWidth-1:0] owner;
        logic                    is_write;
    } tid_entry_t;

    typedef struct packed {
        logic                    found;
        logic [PortIdxWidth-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n (ptr < n <= MaxPorts).
    function automatic rr_pick_t rr_first(input logic [MaxPorts-1:0]     req,
                                          input logic [PortIdxWidth-1:0] ptr,
                                          input logic [PortCntWidth-1:0] n);
        rr_pick_t                pick;
        logic [PortCntWidth-1:0] cand;
        pick = '0;
        for (int unsigned k = 0; k < MaxPorts; k++) begin
            cand = {1'b0, ptr} + PortCntWidth'(k);
            if (cand >= n) cand = cand - n;
            if (!pick.found && (PortCntWidth'(k) < n) && req[cand[PortIdxWidth-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[PortIdxWidth-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester, downstream memory and response signals of the arbiter.
interface mem_req_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned NrPorts   = NrPortsDefault,
    parameter int unsigned TidWidth  = TidWidthDefault,
    parameter int unsigned AddrWidth = AddrWidthDefault,
    parameter int unsigned DataWidth = DataWidthDefault
);
    logic [NrPorts-1:0]           req_valid_i;
    logic [NrPorts-1:0]           req_ready_o;
    logic [NrPorts-1:0]           req_we_i;
    logic [NrPorts*AddrWidth-1:0] req_addr_i;
    logic [NrPorts*DataWidth-1:0] req_wdata_i;
    logic                         mem_valid_o;
    logic                         mem_ready_i;
    logic                         mem_we_o;
    logic [AddrWidth-1:0]         mem_addr_o;
    logic [DataWidth-1:0]         mem_wdata_o;
    logic [TidWidth-1:0]          mem_tid_o;
    logic                         rsp_valid_i;
    logic [TidWidth-1:0]          rsp_tid_i;
    logic [DataWidth-1:0]         rsp_rdata_i;
    logic [NrPorts-1:0]           rsp_valid_o;
    logic [DataWidth-1:0]         rsp_rdata_o;
    logic                         rsp_err_o;
    logic                         idle_o;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  mem_ready_i, rsp_valid_i, rsp_tid_i, rsp_rdata_i,
        output req_ready_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_tid_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, idle_o
    );

    // Requesters and memory side.
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output mem_ready_i, rsp_valid_i, rsp_tid_i, rsp_rdata_i,
        input  req_ready_o, mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_tid_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, idle_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick plus a pointer that follows the last grant.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumReq = NrPortsDefault
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req,
    input  logic                    advance,
    output logic [PortIdxWidth-1:0] grant_idx_c,
    output logic                    grant_valid_c
);
    logic [PortIdxWidth-1:0] ptr_q;
    rr_pick_t                pick;

    // Search from the pointer, wrapping over the active requesters.
    always_comb begin
        pick          = rr_first(MaxPorts'(req), ptr_q, PortCntWidth'(NumReq));
        grant_idx_c   = pick.idx;
        grant_valid_c = pick.found;
    end

    // Pointer moves just past the port that was granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance) begin
            if (grant_idx_c == PortIdxWidth'(NumReq - 1)) ptr_q <= '0;
            else                                          ptr_q <= grant_idx_c + PortIdxWidth'(1);
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory request channel among requesters, tags requests with TIDs
// and routes responses back to their owners. MEM_ARB_PERF_EN adds stall_cnt_o.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NrPorts              = NrPortsDefault,
    parameter int unsigned TidWidth             = TidWidthDefault,
    parameter int unsigned AddrWidth            = AddrWidthDefault,
    parameter int unsigned DataWidth            = DataWidthDefault,
    parameter int unsigned MaxOutstandingStores = MaxStoresDefault
) (
    input  logic               clk_i,
    input  logic               rst_i,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]        stall_cnt_o,
`endif
    mem_req_arbiter_if.slave   bus
);
    localparam int unsigned NrTids        = 1 << TidWidth;
    localparam int unsigned StoreCntWidth = $clog2(MaxOutstandingStores + 1);

    state_e                        state_q;
    tid_entry_t [NrTids-1:0]       tid_tbl_q;
    logic [StoreCntWidth-1:0]      store_cnt_q;
    logic                          we_q;
    logic [AddrWidth-1:0]          addr_q;
    logic [DataWidth-1:0]          wdata_q;
    logic [TidWidth-1:0]           tid_q;
    logic [PortIdxWidth-1:0]       owner_q;
    logic [NrPorts-1:0]            rsp_valid_q;
    logic [DataWidth-1:0]          rsp_rdata_q;
    logic                          rsp_err_q;

    logic [NrPorts-1:0]            eligible;
    logic [PortIdxWidth-1:0]       grant_idx;
    logic                          grant_any;
    logic                          grant_c;
    logic                          free_found;
    logic [TidWidth-1:0]           free_tid;
    logic                          any_alloc;
    logic                          sel_we;
    logic [AddrWidth-1:0]          sel_addr;
    logic [DataWidth-1:0]          sel_wdata;
    logic                          accept;
    tid_entry_t                    rsp_entry;
    logic                          rsp_hit;
    logic                          store_inc;
    logic                          store_dec;

    rr_arbiter #(.NumReq(NrPorts)) u_rr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req           (eligible),
        .advance       (grant_c),
        .grant_idx_c   (grant_idx),
        .grant_valid_c (grant_any)
    );

    // Eligibility, lowest free TID, winner field mux and response lookup.
    always_comb begin
        eligible   = '0;
        free_found = 1'b0;
        free_tid   = '0;
        any_alloc  = 1'b0;
        sel_we     = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int unsigned p = 0; p < NrPorts; p++) begin
            eligible[p] = bus.req_valid_i[p] &&
                          (!bus.req_we_i[p] || (store_cnt_q < StoreCntWidth'(MaxOutstandingStores)));
            if (grant_idx == PortIdxWidth'(p)) begin
                sel_we    = bus.req_we_i[p];
                sel_addr  = bus.req_addr_i[p*AddrWidth +: AddrWidth];
                sel_wdata = bus.req_wdata_i[p*DataWidth +: DataWidth];
            end
        end
        for (int unsigned t = NrTids; t > 0; t--) begin
            any_alloc = any_alloc | tid_tbl_q[t-1].valid;
            if (!tid_tbl_q[t-1].valid) begin
                free_found = 1'b1;
                free_tid   = TidWidth'(t - 1);
            end
        end
        grant_c   = (state_q == IDLE) && grant_any && free_found && !rst_i;
        accept    = (state_q == ISSUE) && bus.mem_ready_i;
        rsp_entry = tid_tbl_q[bus.rsp_tid_i];
        rsp_hit   = bus.rsp_valid_i && rsp_entry.valid;
        store_inc = accept && we_q;
        store_dec = rsp_hit && rsp_entry.is_write;
    end

    // Grant FSM, TID table, store counter and response return.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tid_tbl_q   <= '0;
            store_cnt_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tid_q       <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_c) begin
                        state_q <= ISSUE;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        tid_q   <= free_tid;
                        owner_q <= grant_idx;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready_i) begin
                        state_q          <= IDLE;
                        tid_tbl_q[tid_q] <= '{valid: 1'b1, owner: owner_q, is_write: we_q};
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A hit TID is always allocated, so it never collides with the one being issued.
            if (rsp_hit) begin
                tid_tbl_q[bus.rsp_tid_i].valid <= 1'b0;
                rsp_valid_q                    <= NrPorts'(1) << rsp_entry.owner;
                rsp_rdata_q                    <= bus.rsp_rdata_i;
            end else if (bus.rsp_valid_i) begin
                rsp_err_q <= 1'b1;
            end
            if (store_inc && !store_dec)      store_cnt_q <= store_cnt_q + StoreCntWidth'(1);
            else if (!store_inc && store_dec) store_cnt_q <= store_cnt_q - StoreCntWidth'(1);
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Cycles with a pending request but no grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                              stall_cnt_o <= '0;
        else if (|bus.req_valid_i && !grant_c)  stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

    assign bus.req_ready_o = grant_c ? (NrPorts'(1) << grant_idx) : '0;
    assign bus.mem_valid_o = (state_q == ISSUE);
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_tid_o   = tid_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.idle_o      = (state_q == IDLE) && !any_alloc;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: cycle table plus store-cap and hold sequences.
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.TidWidth(2)) bus ();
    mem_req_arbiter_if #(.TidWidth(3)) bus_st ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] stall_cnt_st;
`endif

    mem_req_arbiter #(.TidWidth(2)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef MEM_ARB_PERF_EN
        .stall_cnt_o (stall_cnt),
`endif
        .bus         (bus)
    );

    mem_req_arbiter #(.TidWidth(3)) u_dut_st (
        .clk_i       (clk),
        .rst_i       (rst),
`ifdef MEM_ARB_PERF_EN
        .stall_cnt_o (stall_cnt_st),
`endif
        .bus         (bus_st)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  vld;
        logic [2:0]  we;
        logic        mrdy;
        logic        rspv;
        logic [1:0]  rtid;
        logic [63:0] rdata;
        logic [2:0]  e_ready;
        logic        e_mv;
        logic [1:0]  e_tid;
        int          e_port;
        logic [2:0]  e_rspv;
        logic [63:0] e_rdata;
        logic        e_idle;
        logic        e_err;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] addr_tbl [3];
    logic [63:0] wdata_tbl [3];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             n_pass++;
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] vld, input logic [2:0] we,
                                input logic mrdy, input logic rspv, input logic [1:0] rtid,
                                input logic [63:0] rdata, input logic [2:0] e_ready,
                                input logic e_mv, input logic [1:0] e_tid, input int e_port,
                                input logic [2:0] e_rspv, input logic [63:0] e_rdata,
                                input logic e_idle, input logic e_err);
        vec_t v;
        v.rst = r; v.vld = vld; v.we = we; v.mrdy = mrdy; v.rspv = rspv; v.rtid = rtid;
        v.rdata = rdata; v.e_ready = e_ready; v.e_mv = e_mv; v.e_tid = e_tid;
        v.e_port = e_port; v.e_rspv = e_rspv; v.e_rdata = e_rdata; v.e_idle = e_idle;
        v.e_err = e_err;
        return v;
    endfunction

    // Issue one request on the store-cap instance: grant cycle then issue cycle.
    task automatic st_issue(input logic [2:0] vld, input logic [2:0] we, input logic [2:0] e_ready,
                            input int e_port, input logic [2:0] e_tid, input string tag);
        @(negedge clk);
        bus_st.req_valid_i = vld;
        bus_st.req_we_i    = we;
        bus_st.mem_ready_i = 1'b0;
        #1;
        chk({tag, " ready"}, 64'(bus_st.req_ready_o), 64'(e_ready));
        @(negedge clk);
        bus_st.req_valid_i = 3'b000;
        bus_st.mem_ready_i = 1'b1;
        #1;
        chk({tag, " mem_valid"}, 64'(bus_st.mem_valid_o), 64'(1'b1));
        chk({tag, " tid"}, 64'(bus_st.mem_tid_o), 64'(e_tid));
        chk({tag, " addr"}, bus_st.mem_addr_o, addr_tbl[e_port]);
        chk({tag, " we"}, 64'(bus_st.mem_we_o), 64'(we[e_port]));
    endtask

    initial begin
        addr_tbl[0]  = 64'h0000_0000_0000_1000;
        addr_tbl[1]  = 64'h0000_0000_8000_0000;
        addr_tbl[2]  = 64'h0000_0000_0000_2000;
        wdata_tbl[0] = 64'hCAFE_0000_0000_00D0;
        wdata_tbl[1] = 64'hCAFE_0000_0000_00D1;
        wdata_tbl[2] = 64'hCAFE_0000_0000_00D2;

        bus.req_valid_i    = '0; bus.req_we_i = '0; bus.mem_ready_i = 1'b0;
        bus.rsp_valid_i    = 1'b0; bus.rsp_tid_i = '0; bus.rsp_rdata_i = '0;
        bus.req_addr_i     = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
        bus.req_wdata_i    = {wdata_tbl[2], wdata_tbl[1], wdata_tbl[0]};
        bus_st.req_valid_i = '0; bus_st.req_we_i = '0; bus_st.mem_ready_i = 1'b0;
        bus_st.rsp_valid_i = 1'b0; bus_st.rsp_tid_i = '0; bus_st.rsp_rdata_i = '0;
        bus_st.req_addr_i  = {addr_tbl[2], addr_tbl[1], addr_tbl[0]};
        bus_st.req_wdata_i = {wdata_tbl[2], wdata_tbl[1], wdata_tbl[0]};

        //             rst vld     we      mrdy rspv tid  rdata   | ready   mv tid port rspv    rdata   idle err
        // single read on port 1
        vecs.push_back(mk(0, 3'b010, 3'b000, 1, 0, 2'd0, 64'h0,  3'b010, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 1, 2'd0, 1, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 1, 2'd0, 64'hAA, 3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b010, 64'hAA, 1, 0));
        // all ports valid from reset: grants 0,1,2,0 with TIDs 0..3, then pool full
        vecs.push_back(mk(1, 3'b111, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b001, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 1, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b010, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 1, 2'd1, 1, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b100, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 1, 2'd2, 2, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b001, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 1, 2'd3, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 1, 2'd1, 64'h55, 3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b010, 0, 2'd0, 0, 3'b010, 64'h55, 0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 1, 2'd1, 1, 3'b000, 64'h0,  0, 0));
        // reset while issuing: next grant restarts at port 0, TID 0
        vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));
        vecs.push_back(mk(0, 3'b111, 3'b000, 1, 0, 2'd0, 64'h0,  3'b001, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 1, 0, 2'd0, 64'h0,  3'b000, 1, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        // response for an unallocated TID: sticky error until reset
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 1, 2'd3, 64'h77, 3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  0, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  0, 1));
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  0, 1));
        vecs.push_back(mk(1, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));
        vecs.push_back(mk(0, 3'b000, 3'b000, 0, 0, 2'd0, 64'h0,  3'b000, 0, 2'd0, 0, 3'b000, 64'h0,  1, 0));

        repeat (3) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            bus.req_valid_i = vecs[i].vld;
            bus.req_we_i    = vecs[i].we;
            bus.mem_ready_i = vecs[i].mrdy;
            bus.rsp_valid_i = vecs[i].rspv;
            bus.rsp_tid_i   = vecs[i].rtid;
            bus.rsp_rdata_i = vecs[i].rdata;
            #1;
            chk($sformatf("r%0d req_ready", i), 64'(bus.req_ready_o), 64'(vecs[i].e_ready));
            chk($sformatf("r%0d mem_valid", i), 64'(bus.mem_valid_o), 64'(vecs[i].e_mv));
            if (vecs[i].e_mv) begin
                chk($sformatf("r%0d mem_tid", i), 64'(bus.mem_tid_o), 64'(vecs[i].e_tid));
                chk($sformatf("r%0d mem_addr", i), bus.mem_addr_o, addr_tbl[vecs[i].e_port]);
            end
            chk($sformatf("r%0d rsp_valid", i), 64'(bus.rsp_valid_o), 64'(vecs[i].e_rspv));
            if (vecs[i].e_rspv != 3'b000)
                chk($sformatf("r%0d rsp_rdata", i), bus.rsp_rdata_o, vecs[i].e_rdata);
            chk($sformatf("r%0d idle", i), 64'(bus.idle_o), 64'(vecs[i].e_idle));
            chk($sformatf("r%0d rsp_err", i), 64'(bus.rsp_err_o), 64'(vecs[i].e_err));
        end

        // Hold: a write from port 0 stalled 5 cycles keeps its fields; no other grant.
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.rsp_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = 3'b001;
        bus.req_we_i    = 3'b001;
        bus.mem_ready_i = 1'b0;
        #1;
        chk("hold grant", 64'(bus.req_ready_o), 64'(3'b001));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.req_valid_i = 3'b111;
            #1;
            chk($sformatf("hold%0d mem_valid", c), 64'(bus.mem_valid_o), 64'(1'b1));
            chk($sformatf("hold%0d addr", c), bus.mem_addr_o, addr_tbl[0]);
            chk($sformatf("hold%0d wdata", c), bus.mem_wdata_o, wdata_tbl[0]);
            chk($sformatf("hold%0d tid", c), 64'(bus.mem_tid_o), 64'(2'd0));
            chk($sformatf("hold%0d we", c), 64'(bus.mem_we_o), 64'(1'b1));
            chk($sformatf("hold%0d ready", c), 64'(bus.req_ready_o), 64'(3'b000));
        end
        @(negedge clk);
        bus.req_valid_i = 3'b000;
        bus.req_we_i    = 3'b000;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("hold done mem_valid", 64'(bus.mem_valid_o), 64'(1'b0));
        chk("hold done idle", 64'(bus.idle_o), 64'(1'b0));

        // Store cap on the 8-TID instance: 7 writes in flight block the 8th.
        for (int w = 0; w < 7; w++)
            st_issue(3'b100, 3'b100, 3'b100, 2, 3'(w), $sformatf("st_w%0d", w));
        @(negedge clk);
        bus_st.req_valid_i = 3'b100;
        bus_st.req_we_i    = 3'b100;
        bus_st.mem_ready_i = 1'b0;
        #1;
        chk("st cap blocks write", 64'(bus_st.req_ready_o), 64'(3'b000));
        st_issue(3'b101, 3'b100, 3'b001, 0, 3'd7, "st_read");
        @(negedge clk);
        bus_st.mem_ready_i = 1'b0;
        bus_st.rsp_valid_i = 1'b1;
        bus_st.rsp_tid_i   = 3'd0;
        bus_st.rsp_rdata_i = 64'h1234;
        @(negedge clk);
        bus_st.rsp_valid_i = 1'b0;
        #1;
        chk("st write rsp strobe", 64'(bus_st.rsp_valid_o), 64'(3'b100));
        st_issue(3'b100, 3'b100, 3'b100, 2, 3'd0, "st_w8");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
